// File: rtl/lcd_write_decoder.sv
// Receive-side decoder for the 8080-style LCD write bus: rebuilds commands, CASET/PASET windows
// and RGB565 pixel writes, tagging each pixel with its screen coordinates.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no command context; data bytes are flagged as stray
// S_CASET | collecting 4 column-window bytes (sc hi/lo, ec hi/lo)
// S_PASET | collecting 4 row-window bytes (sp hi/lo, ep hi/lo)
// S_RAMWR | pairing data bytes into pixels and walking the window
// S_SKIP  | unknown command; parameter bytes ignored
module lcd_write_decoder #(
  parameter logic [15:0] COL_MAX = 16'd319,
  parameter logic [15:0] ROW_MAX = 16'd239
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        frame_done,
  output logic        stray_data,
  output logic [15:0] win_sc,
  output logic [15:0] win_ec,
  output logic [15:0] win_sp,
  output logic [15:0] win_ep
);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

  state_t      state, state_nxt;
  logic        wr_q;
  logic [1:0]  byte_cnt;
  logic [7:0]  hi_byte;
  logic [15:0] tmp_start;
  logic [7:0]  tmp_end_hi;
  logic [15:0] cur_x, cur_y;

  logic byte_ev, cmd_ev, data_ev;
  logic x_wrap, y_wrap;

  assign byte_ev = wr & ~wr_q;
  assign cmd_ev  = byte_ev & ~dcx;
  assign data_ev = byte_ev & dcx;
  // >= rather than == so a degenerate window (start > end) wraps every step
  assign x_wrap  = (cur_x >= win_ec);
  assign y_wrap  = (cur_y >= win_ep);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cmd_ev) begin
      case (D)
        8'h2A:   state_nxt = S_CASET;
        8'h2B:   state_nxt = S_PASET;
        8'h2C:   state_nxt = S_RAMWR;
        default: state_nxt = S_SKIP;
      endcase
    end else if (data_ev && (state == S_CASET || state == S_PASET) && byte_cnt == 2'd3) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q       <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd        <= 8'h00;
      pix_valid  <= 1'b0;
      pix_x      <= 16'd0;
      pix_y      <= 16'd0;
      pix_color  <= 16'd0;
      frame_done <= 1'b0;
      stray_data <= 1'b0;
      win_sc     <= 16'd0;
      win_ec     <= COL_MAX;
      win_sp     <= 16'd0;
      win_ep     <= ROW_MAX;
      byte_cnt   <= 2'd0;
      hi_byte    <= 8'h00;
      tmp_start  <= 16'd0;
      tmp_end_hi <= 8'h00;
      cur_x      <= 16'd0;
      cur_y      <= 16'd0;
    end else begin
      wr_q       <= wr;
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      stray_data <= 1'b0;
      if (cmd_ev) begin
        cmd_valid <= 1'b1;
        cmd       <= D;
        byte_cnt  <= 2'd0;
        hi_byte   <= 8'h00;
        if (D == 8'h2C) begin
          cur_x <= win_sc;
          cur_y <= win_sp;
        end
      end else if (data_ev) begin
        case (state)
          S_IDLE: stray_data <= 1'b1;
          S_CASET, S_PASET: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: tmp_start[15:8] <= D;
              2'd1: tmp_start[7:0]  <= D;
              2'd2: tmp_end_hi      <= D;
              default: begin
                // both window ends commit together on the final byte
                if (state == S_CASET) begin
                  win_sc <= tmp_start;
                  win_ec <= {tmp_end_hi, D};
                end else begin
                  win_sp <= tmp_start;
                  win_ep <= {tmp_end_hi, D};
                end
              end
            endcase
          end
          S_RAMWR: begin
            if (!byte_cnt[0]) begin
              hi_byte  <= D;
              byte_cnt <= 2'd1;
            end else begin
              byte_cnt  <= 2'd0;
              pix_valid <= 1'b1;
              pix_x     <= cur_x;
              pix_y     <= cur_y;
              pix_color <= {hi_byte, D};
              if (x_wrap) begin
                cur_x <= win_sc;
                if (y_wrap) begin
                  cur_y      <= win_sp;
                  frame_done <= 1'b1;
                end else begin
                  cur_y <= cur_y + 16'd1;
                end
              end else begin
                cur_x <= cur_x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_decoder.sv
// Directed bench for lcd_write_decoder: drives bus bytes at the minimum 2-cycle spacing and
// compares decoded pulses, pixels and window registers against hand-computed values.
module tb_lcd_write_decoder;

  logic        clk = 1'b0;
  logic        nrst, wr, dcx;
  logic [7:0]  D;
  logic        cmd_valid, pix_valid, frame_done, stray_data;
  logic [7:0]  cmd;
  logic [15:0] pix_x, pix_y, pix_color, win_sc, win_ec, win_sp, win_ep;

  int n_vec = 0;
  int n_miss = 0;

  lcd_write_decoder dut (
    .clk(clk), .nrst(nrst), .wr(wr), .dcx(dcx), .D(D),
    .cmd_valid(cmd_valid), .cmd(cmd), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done), .stray_data(stray_data),
    .win_sc(win_sc), .win_ec(win_ec), .win_sp(win_sp), .win_ep(win_ep)
  );

  always #5 clk = ~clk;

  // pulse monitor, sampled away from the active edge
  logic [15:0] cap_x [0:4095];
  logic [15:0] cap_y [0:4095];
  logic [15:0] cap_c [0:4095];
  logic        cap_f [0:4095];
  int pix_n = 0, cmd_n = 0, stray_n = 0, fd_n = 0;

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      if (pix_n < 4096) begin
        cap_x[pix_n] = pix_x;
        cap_y[pix_n] = pix_y;
        cap_c[pix_n] = pix_color;
        cap_f[pix_n] = frame_done;
      end
      pix_n++;
    end
    if (cmd_valid === 1'b1)  cmd_n++;
    if (stray_data === 1'b1) stray_n++;
    if (frame_done === 1'b1) fd_n++;
  end

  task automatic send_byte(input logic is_data, input logic [7:0] b);
    @(negedge clk) wr = 1'b0;
    @(negedge clk) begin wr = 1'b1; dcx = is_data; D = b; end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    int c0, s0;
    nrst = 1'b0; wr = 1'b1; dcx = 1'b0; D = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd !== 8'h00) begin n_miss++; $display("FAIL reset_cmd got %h want 00", cmd); end
    n_vec++; if ({pix_x, pix_y, pix_color} !== 48'd0) begin n_miss++; $display("FAIL reset_pix got %h/%h/%h want 0", pix_x, pix_y, pix_color); end
    n_vec++; if ({cmd_valid, pix_valid, frame_done, stray_data} !== 4'b0) begin n_miss++; $display("FAIL reset_pulses got %b want 0000", {cmd_valid, pix_valid, frame_done, stray_data}); end
    n_vec++; if ({win_sc, win_ec, win_sp, win_ep} !== {16'd0, 16'd319, 16'd0, 16'd239}) begin n_miss++; $display("FAIL reset_win got %0d,%0d,%0d,%0d want 0,319,0,239", win_sc, win_ec, win_sp, win_ep); end
    c0 = cmd_n; s0 = stray_n;
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (cmd_n - c0 + stray_n - s0 !== 0) begin n_miss++; $display("FAIL reset_high_wr got %0d events want 0", cmd_n - c0 + stray_n - s0); end
  endtask

  task automatic test_first_pixel();
    int p0, c0;
    p0 = pix_n; c0 = cmd_n;
    send_byte(0, 8'h2C); send_byte(1, 8'hF8); send_byte(1, 8'h00); settle();
    n_vec++; if (cmd_n - c0 !== 1 || cmd !== 8'h2C) begin n_miss++; $display("FAIL first_cmd got n=%0d cmd=%h want 1/2c", cmd_n - c0, cmd); end
    n_vec++; if (pix_n - p0 !== 1) begin n_miss++; $display("FAIL first_count got %0d want 1", pix_n - p0); end
    n_vec++; if ({cap_x[p0], cap_y[p0], cap_c[p0]} !== {16'd0, 16'd0, 16'hF800} || cap_f[p0] !== 1'b0) begin n_miss++; $display("FAIL first_pix got (%0d,%0d) %h fd=%b want (0,0) f800 fd=0", cap_x[p0], cap_y[p0], cap_c[p0], cap_f[p0]); end
    n_vec++; if (win_ec !== 16'd319 || win_ep !== 16'd239) begin n_miss++; $display("FAIL first_win got %0d/%0d want 319/239", win_ec, win_ep); end
  endtask

  task automatic test_window();
    int p0, f0;
    logic [15:0] ex [0:6];
    logic [15:0] ey [0:6];
    ex = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12, 16'd10};
    ey = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd5};
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h0A); send_byte(1, 8'h00); send_byte(1, 8'h0C);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'h05); send_byte(1, 8'h00); send_byte(1, 8'h06);
    settle();
    n_vec++; if ({win_sc, win_ec, win_sp, win_ep} !== {16'd10, 16'd12, 16'd5, 16'd6}) begin n_miss++; $display("FAIL window_regs got %0d,%0d,%0d,%0d want 10,12,5,6", win_sc, win_ec, win_sp, win_ep); end
    p0 = pix_n; f0 = fd_n;
    send_byte(0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      send_byte(1, 8'hA0); send_byte(1, 8'(i));
    end
    settle();
    n_vec++; if (pix_n - p0 !== 7 || fd_n - f0 !== 1) begin n_miss++; $display("FAIL window_counts got pix=%0d fd=%0d want 7/1", pix_n - p0, fd_n - f0); end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (cap_x[p0+i] !== ex[i] || cap_y[p0+i] !== ey[i] || cap_c[p0+i] !== {8'hA0, 8'(i)} || cap_f[p0+i] !== (i == 5)) begin
        n_miss++;
        $display("FAIL window_pix%0d got (%0d,%0d) %h fd=%b want (%0d,%0d) %h fd=%b", i, cap_x[p0+i], cap_y[p0+i], cap_c[p0+i], cap_f[p0+i], ex[i], ey[i], {8'hA0, 8'(i)}, i == 5);
      end
    end
  endtask

  task automatic test_partial_caset();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h20);
    send_byte(0, 8'h2B); settle();
    n_vec++; if (win_sc !== 16'd10 || win_ec !== 16'd12) begin n_miss++; $display("FAIL partial_caset got %0d/%0d want 10/12", win_sc, win_ec); end
    send_byte(1, 8'h00); send_byte(1, 8'h07); send_byte(1, 8'h00); send_byte(1, 8'h08); settle();
    n_vec++; if (win_sp !== 16'd7 || win_ep !== 16'd8 || win_sc !== 16'd10) begin n_miss++; $display("FAIL partial_then_paset got sp=%0d ep=%0d sc=%0d want 7/8/10", win_sp, win_ep, win_sc); end
  endtask

  task automatic test_abort_pixel();
    int p0;
    p0 = pix_n;
    send_byte(0, 8'h2C); send_byte(1, 8'h12); send_byte(0, 8'h2C); send_byte(1, 8'h34); send_byte(1, 8'h56); settle();
    n_vec++; if (pix_n - p0 !== 1) begin n_miss++; $display("FAIL abort_count got %0d want 1", pix_n - p0); end
    n_vec++; if ({cap_x[p0], cap_y[p0], cap_c[p0]} !== {16'd10, 16'd7, 16'h3456}) begin n_miss++; $display("FAIL abort_pix got (%0d,%0d) %h want (10,7) 3456", cap_x[p0], cap_y[p0], cap_c[p0]); end
  endtask

  task automatic test_reset_mid_pixel();
    int p0, s0;
    send_byte(0, 8'h2C); send_byte(1, 8'hF0);
    @(negedge clk) nrst = 1'b0;
    #1;
    n_vec++; if (cmd !== 8'h00 || pix_x !== 16'd0 || pix_y !== 16'd0 || pix_color !== 16'd0) begin n_miss++; $display("FAIL async_reset_out got cmd=%h pix=%0d,%0d,%h want 0", cmd, pix_x, pix_y, pix_color); end
    n_vec++; if ({win_sc, win_ec, win_sp, win_ep} !== {16'd0, 16'd319, 16'd0, 16'd239}) begin n_miss++; $display("FAIL async_reset_win got %0d,%0d,%0d,%0d want 0,319,0,239", win_sc, win_ec, win_sp, win_ep); end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    p0 = pix_n; s0 = stray_n;
    send_byte(1, 8'h77); settle();
    n_vec++; if (pix_n - p0 !== 0 || stray_n - s0 !== 1) begin n_miss++; $display("FAIL post_reset_data got pix=%0d stray=%0d want 0/1", pix_n - p0, stray_n - s0); end
    send_byte(0, 8'h2C); send_byte(1, 8'hAB); send_byte(1, 8'hCD); settle();
    n_vec++; if (pix_n - p0 !== 1 || {cap_x[p0], cap_y[p0], cap_c[p0]} !== {16'd0, 16'd0, 16'hABCD}) begin n_miss++; $display("FAIL post_reset_pix got n=%0d (%0d,%0d) %h want 1 (0,0) abcd", pix_n - p0, cap_x[p0], cap_y[p0], cap_c[p0]); end
  endtask

  task automatic test_stray();
    int p0, c0, s0;
    do_reset();
    p0 = pix_n; c0 = cmd_n; s0 = stray_n;
    send_byte(1, 8'h55); settle();
    n_vec++; if (stray_n - s0 !== 1 || pix_n - p0 !== 0 || cmd_n - c0 !== 0) begin n_miss++; $display("FAIL stray got stray=%0d pix=%0d cmd=%0d want 1/0/0", stray_n - s0, pix_n - p0, cmd_n - c0); end
    s0 = stray_n;
    send_byte(0, 8'h11); send_byte(1, 8'h01); send_byte(1, 8'h02); send_byte(1, 8'h03); settle();
    n_vec++; if (cmd_n - c0 !== 1 || cmd !== 8'h11 || stray_n - s0 !== 0 || pix_n - p0 !== 0) begin n_miss++; $display("FAIL skip got cmd=%0d/%h stray=%0d pix=%0d want 1/11/0/0", cmd_n - c0, cmd, stray_n - s0, pix_n - p0); end
  endtask

  task automatic test_back_to_back();
    int p0, f0, errs;
    logic [15:0] c;
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h00); send_byte(1, 8'h00); send_byte(1, 8'd39);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'h00); send_byte(1, 8'h00); send_byte(1, 8'd29);
    p0 = pix_n; f0 = fd_n;
    send_byte(0, 8'h2C);
    for (int i = 0; i < 1200; i++) begin
      c = 16'(i * 7 + 3);
      send_byte(1, c[15:8]); send_byte(1, c[7:0]);
    end
    settle();
    n_vec++; if (pix_n - p0 !== 1200) begin n_miss++; $display("FAIL b2b_count got %0d want 1200", pix_n - p0); end
    n_vec++; if (fd_n - f0 !== 1 || cap_f[p0+1199] !== 1'b1) begin n_miss++; $display("FAIL b2b_frame_done got n=%0d last=%b want 1/1", fd_n - f0, cap_f[p0+1199]); end
    errs = 0;
    for (int i = 0; i < 1200; i++)
      if (cap_x[p0+i] !== 16'(i % 40) || cap_y[p0+i] !== 16'(i / 40) || cap_c[p0+i] !== 16'(i * 7 + 3)) errs++;
    n_vec++; if (errs !== 0) begin n_miss++; $display("FAIL b2b_scan got %0d bad pixels want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_window();
    test_partial_caset();
    test_abort_pixel();
    test_reset_mid_pixel();
    test_stray();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
